// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// Issue/response controller that sits between the EX stage and an iterative
// divider. It accepts one divide request at a time, latches the operands,
// runs the divider until it reports completion, then holds the quotient and
// remainder until the consumer takes them. A watchdog ends operations that
// never complete.
//
// Ports
//   div_clk       clock, all state updates on the rising edge
//   resetn        synchronous active-low reset
//   req_valid     request valid from EX
//   req_ready     controller idle and able to take a request
//   req_signed    request is a signed divide
//   req_x, req_y  dividend, divisor
//   div           divider enable (high only while running)
//   div_signed    signedness to the divider (from the operand register)
//   div_x, div_y  dividend, divisor to the divider (from operand registers)
//   choke         freezes the divider while a result waits
//   div_s, div_r  divider quotient and remainder
//   div_complete  divider result valid (honoured only while running)
//   rsp_valid     result available
//   rsp_ready     consumer takes the result
//   rsp_lo        quotient
//   rsp_hi        remainder
//   busy          controller not idle
//   cyc_cnt       cycles spent running the current operation (saturates at 63)
//
// Configuration
//   DIV_ZERO_BYPASS_EN  when defined, a zero divisor skips the divider and
//                       returns quotient all-ones, remainder = dividend after
//                       a single extra state. Undefined: normal divider path.
// -----------------------------------------------------------------------------
module div_issue_ctrl (
    input  logic        div_clk,
    input  logic        resetn,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,

    output logic        div,
    output logic        div_signed,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    output logic        choke,

    input  logic [31:0] div_s,
    input  logic [31:0] div_r,
    input  logic        div_complete,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,

    output logic        busy,
    output logic [5:0]  cyc_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef DIV_ZERO_BYPASS_EN
    localparam logic [1:0] S_ZERO = 2'd3;
`endif

    localparam logic [5:0] CYC_MAX = 6'd63;

    logic [1:0]  state_q,     state_d;
    logic        op_signed_q, op_signed_d;
    logic [31:0] op_x_q,      op_x_d;
    logic [31:0] op_y_q,      op_y_d;
    logic [5:0]  cyc_cnt_q,   cyc_cnt_d;
    logic [31:0] rsp_lo_q,    rsp_lo_d;
    logic [31:0] rsp_hi_q,    rsp_hi_d;

    always_comb begin
        state_d     = state_q;
        op_signed_d = op_signed_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        cyc_cnt_d   = cyc_cnt_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_hi_d    = rsp_hi_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_signed_d = req_signed;
                    op_x_d      = req_x;
                    op_y_d      = req_y;
                    cyc_cnt_d   = '0;
`ifdef DIV_ZERO_BYPASS_EN
                    if (req_y == '0) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d = S_RUN;
                    end
`else
                    state_d = S_RUN;
`endif
                end
            end

            S_RUN: begin
                if (cyc_cnt_q != CYC_MAX) begin
                    cyc_cnt_d = cyc_cnt_q + 6'd1;
                end
                // A real completion wins over the watchdog in the same cycle.
                if (div_complete) begin
                    rsp_lo_d = div_s;
                    rsp_hi_d = div_r;
                    state_d  = S_DONE;
                end else if (cyc_cnt_q == CYC_MAX) begin
                    rsp_lo_d = '1;
                    rsp_hi_d = '1;
                    state_d  = S_DONE;
                end
            end

`ifdef DIV_ZERO_BYPASS_EN
            S_ZERO: begin
                rsp_lo_d = '1;
                rsp_hi_d = op_x_q;
                state_d  = S_DONE;
            end
`endif

            S_DONE: begin
                // Return to idle only; a new request waits one more cycle.
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge div_clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_signed_q <= 1'b0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            cyc_cnt_q   <= '0;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_signed_q <= op_signed_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            cyc_cnt_q   <= cyc_cnt_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_hi_q    <= rsp_hi_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign div        = (state_q == S_RUN);
    assign choke      = (state_q == S_DONE);
    assign rsp_valid  = (state_q == S_DONE);

    // Divider operands come only from the latched registers so they cannot
    // move while the divider iterates or while the result is held.
    assign div_signed = op_signed_q;
    assign div_x      = op_x_q;
    assign div_y      = op_y_q;

    assign rsp_lo     = rsp_lo_q;
    assign rsp_hi     = rsp_hi_q;
    assign cyc_cnt    = cyc_cnt_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
`timescale 1ns/1ps
module tb_div_issue_ctrl;

    logic        div_clk = 1'b0;
    logic        resetn  = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_signed = 1'b0;
    logic [31:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic        div;
    logic        div_signed;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        choke;
    logic [31:0] div_s;
    logic [31:0] div_r;
    logic        div_complete;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        busy;
    logic [5:0]  cyc_cnt;

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    div_issue_ctrl dut (
        .div_clk      (div_clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_signed   (req_signed),
        .req_x        (req_x),
        .req_y        (req_y),
        .div          (div),
        .div_signed   (div_signed),
        .div_x        (div_x),
        .div_y        (div_y),
        .choke        (choke),
        .div_s        (div_s),
        .div_r        (div_r),
        .div_complete (div_complete),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_lo       (rsp_lo),
        .rsp_hi       (rsp_hi),
        .busy         (busy),
        .cyc_cnt      (cyc_cnt)
    );

    always #5 div_clk = ~div_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference divide: truncating division, zero divisor gives all-ones
    // quotient and the dividend as remainder, signed overflow wraps.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] q;
        logic [31:0] r;
        if (y == 32'd0) begin
            q = '1;
            r = x;
        end else if (s) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = x;
                r = '0;
            end else begin
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
            end
        end else begin
            q = x / y;
            r = x % y;
        end
        return {q, r};
    endfunction

    // Divider stand-in: completes in its 34th enabled cycle, frozen by choke.
    int unsigned dcnt = 0;
    bit          complete_en = 1'b1;
    logic [63:0] stub_res;

    always @(posedge div_clk) begin
        if (!resetn)      dcnt <= 0;
        else if (div)     dcnt <= dcnt + 1;
        else if (!choke)  dcnt <= 0;
    end

    assign div_complete = div && complete_en && (dcnt == 33);
    assign stub_res     = ref_div(div_signed, div_x, div_y);
    assign div_s        = div_complete ? stub_res[63:32] : 32'hDEAD_BEEF;
    assign div_r        = div_complete ? stub_res[31:0]  : 32'h0BAD_F00D;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int unsigned lat;
        logic [5:0]  cyc;
        bit          div_used;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: samples on the falling edge, checks responses against the queue.
    bit          mon_en     = 1'b0;
    int unsigned tcyc       = 0;
    logic        prev_valid = 1'b0;
    bit          chk_low    = 1'b0;
    bit          div_seen   = 1'b0;
    logic        op_s       = 1'b0;
    logic [31:0] op_x       = '0;
    logic [31:0] op_y       = '0;

    always @(negedge div_clk) begin
        if (mon_en) begin
            tcyc++;
            check("busy_vs_req_ready", busy, !req_ready);
            check("choke_vs_rsp_valid", choke, rsp_valid);
            if (div) div_seen = 1'b1;
            if (busy) begin
                check("div_x_stable", div_x, op_x);
                check("div_y_stable", div_y, op_y);
                check("div_signed_stable", div_signed, op_s);
            end
            if (chk_low) begin
                check("rsp_valid_one_cycle", rsp_valid, 1'b0);
                chk_low = 1'b0;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
                end else begin
                    if (!prev_valid) begin
                        check("rsp_latency", tcyc, exp_q[0].lat);
                        check("cyc_cnt_at_done", cyc_cnt, exp_q[0].cyc);
                        check("div_asserted", div_seen, exp_q[0].div_used);
                    end
                    check("rsp_lo", rsp_lo, exp_q[0].lo);
                    check("rsp_hi", rsp_hi, exp_q[0].hi);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        chk_low = 1'b1;
                    end
                end
            end
            if (req_valid && req_ready && resetn) begin
                tcyc     = 0;
                op_s     = req_signed;
                op_x     = req_x;
                op_y     = req_y;
                div_seen = 1'b0;
            end
        end
        prev_valid = rsp_valid;
    end

    // Stimulus: everything driven 2ns after the rising edge.
    task automatic tick();
        @(posedge div_clk);
        #2;
    endtask

    task automatic push_exp(input logic s, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [63:0] r;
        r = ref_div(s, x, y);
        if (!complete_en) begin
            e.lo = '1; e.hi = '1; e.lat = 65; e.cyc = 6'd63; e.div_used = 1'b1;
        end else if (ZB && y == 32'd0) begin
            e.lo = r[63:32]; e.hi = r[31:0]; e.lat = 2; e.cyc = 6'd0; e.div_used = 1'b0;
        end else begin
            e.lo = r[63:32]; e.hi = r[31:0]; e.lat = 35; e.cyc = 6'd34; e.div_used = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        int unsigned n = 0;
        while (!req_ready && n < 300) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: got req_ready=0 expected 1 within 300 cycles");
        end else begin
            push_exp(s, x, y);
            req_valid  = 1'b1;
            req_signed = s;
            req_x      = x;
            req_y      = y;
            tick();
            req_valid  = 1'b0;
            req_x      = $urandom;
            req_y      = $urandom;
            req_signed = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain(input int unsigned ready_pct);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            rsp_ready = ($urandom_range(0, 99) < ready_pct);
            tick();
            n++;
        end
        rsp_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y, input int unsigned ready_pct);
        issue(s, x, y);
        drain(ready_pct);
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, req_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_div"}, div, 1'b0);
        check({tag, "_choke"}, choke, 1'b0);
        check({tag, "_cyc_cnt"}, cyc_cnt, 6'd0);
        check({tag, "_div_x"}, div_x, 32'd0);
        check({tag, "_div_y"}, div_y, 32'd0);
        check({tag, "_div_signed"}, div_signed, 1'b0);
        check({tag, "_rsp_lo"}, rsp_lo, 32'd0);
        check({tag, "_rsp_hi"}, rsp_hi, 32'd0);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        int unsigned n;

        resetn = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        resetn = 1'b1;
        mon_en = 1'b1;
        tick();

        // Unsigned and signed nominal operations, consumer always ready.
        run_op(1'b0, 32'd100, 32'd7, 100);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 100);

        // Result held under backpressure; requests ignored while DONE.
        issue(1'b0, 32'd100, 32'd7);
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check("stall_rsp_seen", rsp_valid, 1'b1);
        req_valid = 1'b1;
        req_signed = 1'b0;
        req_x = 32'd55;
        req_y = 32'd3;
        for (int unsigned i = 0; i < 10; i++) begin
            check("stall_req_ready", req_ready, 1'b0);
            check("stall_choke", choke, 1'b1);
            check("stall_rsp_valid", rsp_valid, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        // No bypass: the handshake edge only returns to idle.
        check("no_bypass_busy", busy, 1'b0);
        check("no_bypass_req_ready", req_ready, 1'b1);
        push_exp(1'b0, 32'd55, 32'd3);
        tick();
        req_valid = 1'b0;
        drain(100);
        tick();

        // Reset in the 12th RUN cycle abandons the operation.
        issue(1'b0, 32'd100, 32'd7);
        for (int unsigned i = 1; i < 12; i++) tick();
        check("mid_run_div", div, 1'b1);
        resetn = 1'b0;
        exp_q.delete();
        tick();
        resetn = 1'b1;
        check_reset_state("mid_reset");
        for (int unsigned i = 0; i < 40; i++) tick();
        run_op(1'b0, 32'd5, 32'd5, 100);

        // Watchdog: divider never completes.
        complete_en = 1'b0;
        run_op(1'b0, 32'd123, 32'd4, 100);
        complete_en = 1'b1;

        // Zero divisor and edge operands.
        run_op(1'b0, 32'd9, 32'd0, 100);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 100);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 70);

        // Randomized operations with random consumer backpressure.
        for (int unsigned i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1, 2:    y = $urandom_range(1, 15);
                3:       y = -($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            run_op(s, x, y, 60);
        end

        for (int unsigned i = 0; i < 5; i++) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have port div_clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports req_valid  input  1 and req_ready  output  1: request handshake from the EX stage.
REQ-004 SHALL have ports req_signed  input  1, req_x  input  32 and req_y  input  32: signedness, dividend and divisor.
REQ-005 SHALL have ports div  output  1, div_signed  output  1, div_x  output  32, div_y  output  32 and choke  output  1: drive to the divider.
REQ-006 SHALL have ports div_s  input  32, div_r  input  32 and div_complete  input  1: divider results.
REQ-007 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_lo  output  32 (quotient) and rsp_hi  output  32 (remainder): result handshake.
REQ-008 SHALL have port busy  output  1, high whenever the state is not IDLE.
REQ-009 SHALL have port cyc_cnt  output  6: cycles spent in RUN for the current operation.

Function
REQ-010 SHALL implement states IDLE, RUN and DONE; ZERO exists only under REQ-026.
REQ-011 IDLE SHALL assert req_ready=1; req_ready SHALL be 0 in every other state.
REQ-012 IDLE with req_valid=1 SHALL latch req_signed, req_x and req_y into operand registers, clear cyc_cnt to 0, and go to RUN.
REQ-013 div_x, div_y and div_signed SHALL come only from the operand registers and SHALL stay constant from RUN entry until return to IDLE.
REQ-014 div SHALL be 1 in every RUN cycle and 0 in every other state; the divider advances only while div=1.
REQ-015 In RUN, cyc_cnt SHALL increment by 1 per cycle and saturate at 63.
REQ-016 In RUN with div_complete=1, the block SHALL capture div_s into rsp_lo and div_r into rsp_hi in that cycle and go to DONE.
REQ-017 Nominal latency: div_complete arrives in the 34th RUN cycle; rsp_valid SHALL rise on the next edge, i.e. 35 cycles after the req handshake edge.
REQ-018 DONE SHALL assert rsp_valid=1 with rsp_lo and rsp_hi held stable until rsp_ready=1.
REQ-019 DONE with rsp_ready=1 SHALL return to IDLE on the next edge; a new request is not accepted in that same cycle (no back-to-back bypass).
REQ-020 choke SHALL be 1 in DONE and 0 otherwise, freezing the divider counter while the result waits.
REQ-021 div_complete outside RUN SHALL be ignored.
REQ-022 req_valid outside IDLE SHALL be ignored; no queuing, and the upstream stage holds its request.
REQ-023 If RUN reaches cyc_cnt=63 without div_complete, the block SHALL go to DONE with rsp_lo=rsp_hi=32'hFFFFFFFF (watchdog).

Reset
REQ-024 With resetn=0 at an edge, the block SHALL set state=IDLE, req_ready=1, rsp_valid=0, div=0, choke=0, busy=0, cyc_cnt=0, and clear operand and result registers to 0.
REQ-025 Reset mid-RUN or mid-DONE SHALL abandon the operation with no rsp_valid pulse; the divider shares resetn and is reset in the same cycle.

Configuration
REQ-026 With macro DIV_ZERO_BYPASS_EN defined, an accepted request with req_y=0 SHALL go to ZERO instead of RUN, keep div=0, and in the next cycle go to DONE with rsp_lo=32'hFFFFFFFF and rsp_hi=req_x, giving rsp_valid 2 cycles after acceptance.
REQ-027 Without DIV_ZERO_BYPASS_EN, ZERO SHALL not exist and req_y=0 SHALL follow the normal RUN path.

Verification
REQ-028 Unsigned 100/7 with rsp_ready=1 -> rsp_lo=14, rsp_hi=2, rsp_valid 35 cycles after acceptance, lasting 1 cycle.
REQ-029 Signed -100/7 -> rsp_lo=32'hFFFFFFF2, rsp_hi=32'hFFFFFFFE; div_x and div_y stable throughout RUN.
REQ-030 Result completes with rsp_ready=0 for 10 cycles -> rsp_valid and data held, choke=1, req_ready=0, new req_valid ignored.
REQ-031 resetn=0 at RUN cycle 12 -> IDLE next edge, no rsp_valid; the next request 5/5 returns lo=1, hi=0.
REQ-032 div_complete tied 0 -> watchdog at cyc_cnt=63 gives rsp_lo=rsp_hi=32'hFFFFFFFF.
REQ-033 With DIV_ZERO_BYPASS_EN, 9/0 -> div never asserted, rsp_lo=32'hFFFFFFFF, rsp_hi=9 after 2 cycles; without it, the normal RUN path is taken.
